mc_request_arbiter: RTL and testbench
=====================================

# mc_request_arbiter

Front-end arbiter that shares the single `memory_controller` request port between `NUM_REQ` requesters. It round-robin grants one request per cycle and forwards it through a one-entry output register that honours the controller's `out_busy` backpressure. It tracks which requester owns each outstanding read and write, and routes `read_done` with `data_out`, and `write_done`, back to that requester in order. It sits directly between the client masters and `memory_controller`.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 16, request/read data width
- `ADDR_WIDTH`, 30, request address width
- `TAG_DEPTH`, 16, entries in each ownership FIFO (power of 2)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in NUM_REQ: request pending, one bit per requester
- `req_ready` out NUM_REQ: grant; one-hot or zero, combinational
- `req_type` in NUM_REQ: 1 = write, 0 = read
- `req_addr` in NUM_REQ×ADDR_WIDTH: packed per-requester address
- `req_data` in NUM_REQ×DATA_WIDTH: packed per-requester write data
- `in_valid` out 1: to controller
- `in_request_type` out 1: to controller
- `in_request_address` out ADDR_WIDTH: to controller
- `in_request_data` out DATA_WIDTH: to controller
- `out_busy` in 1: controller cannot accept this cycle
- `read_done` in 1: controller read completion
- `write_done` in 1: controller write completion
- `data_out` in DATA_WIDTH: controller read data
- `rsp_rd_valid` out NUM_REQ: one-hot read completion
- `rsp_wr_valid` out NUM_REQ: one-hot write completion
- `rsp_data` out DATA_WIDTH: read data, shared by all requesters
- `err_orphan` out 1: one-cycle pulse on a completion with an empty FIFO

## Operation
- **Output slot:** one register holding {type, addr, data, id}. It is accepted in a cycle where `in_valid && !out_busy`. It is free when `!in_valid` or when it is being accepted that cycle.
- **Eligibility:** requester i is eligible when `req_valid[i]` is set and the target FIFO has room. Reads need the read FIFO not full; writes need the write FIFO not full.
- **Full FIFO:** the full check ignores a same-cycle pop, so no push happens into a full FIFO.
- **Grant:** if the slot is free and any requester is eligible, grant the first eligible index searching from `rr_ptr` upward with wrap.
  - Assert `req_ready[g]`, load the slot, and push g into the read or write FIFO.
  - Set `rr_ptr <= (g+1) mod NUM_REQ`.
  - With no grant, `rr_ptr` holds.
- **Ineligible requesters:** skipped without losing their turn order. Their `req_valid` must stay asserted until `req_ready`.
- **Read completion:** `read_done` pops the read FIFO head h. Next cycle: `rsp_rd_valid[h]=1` and `rsp_data=data_out` captured.
- **Write completion:** `write_done` pops the write FIFO and pulses `rsp_wr_valid[h]` the next cycle.
- **Orphan completion:** `read_done` or `write_done` with its FIFO empty sets `err_orphan=1` next cycle, with no rsp pulse and no pop.
- **Simultaneous events:** a push and pop on the same FIFO in one cycle are both performed, so the count is unchanged. `read_done` and `write_done` together are both handled independently.
- **Reset values:** all outputs 0; `rr_ptr=0`; FIFOs empty; slot empty.
- **Reset mid-operation:** the slot and outstanding ownership are discarded. Completions after reset with empty FIFOs raise `err_orphan`.

## Timing
- Handshake at cycle N → `in_valid` with the payload at N+1.
- With `out_busy` low, back-to-back grants sustain one request per cycle.
- `out_busy` high holds the slot stable; the next grant occurs in the cycle the slot is accepted.
- Completion at cycle N → rsp pulse at N+1, exactly one cycle wide.
- `req_ready` depends combinationally on `req_valid`, `req_type`, `out_busy`, `in_valid`, `rr_ptr` and FIFO counts. It has no path from `req_addr` or `req_data`.

## Structure
- **Package `mc_arb_pkg`:**
  - `ID_W = $clog2(NUM_REQ)` helper function
  - `mc_req_t` struct {type, addr, data, id}
  - `REQ_WRITE`/`REQ_READ` constants
- **Sub-module `mc_tag_fifo`:** a synchronous FIFO with width ID_W and depth TAG_DEPTH, providing full, empty and count. It is instantiated twice, once for reads and once for writes.
- **Top level:** the round-robin picker, output slot and response registers live in `mc_request_arbiter`.

## Test plan
- **Round-robin fairness:** all 4 requesters hold writes, `out_busy=0` → `in_valid` ids sequence 0,1,2,3,0,…, one per cycle starting 1 cycle after the first grant.
- **Backpressure:** `out_busy=1` for 5 cycles with requester 2 write addr 0x15 → slot stable for 5 cycles, accepted on the 6th, no extra grants.
- **Read routing:** reads from requesters 1, 3, 1; then `read_done` ×3 with `data_out` 0xA, 0xB, 0xC → `rsp_rd_valid` 0010/0xA, 1000/0xB, 0010/0xC, each 1 cycle after its `read_done`.
- **Read FIFO full:** 16 reads outstanding and a further read pending → that read gets no `req_ready`, while a concurrent write from another requester is granted. One `read_done` → the read is granted on the following cycle.
- **Orphan completion:** `write_done` with an empty write FIFO → `err_orphan` is a 1-cycle pulse and all `rsp_wr_valid=0`.
- **Reset mid-traffic:** `rst_n` low with 3 reads outstanding → all outputs 0 and `rr_ptr=0`. A later `read_done` → `err_orphan`.

Source files
------------

// File: rtl/mc_arb_pkg.sv
// rtl/mc_arb_pkg.sv - shared types and helpers for the memory-controller request arbiter
//
// Purpose: request-type encodings, the id-width helper and the canonical
//          request record {type, addr, data, id} at the default geometry.
// Ports:   none (package).
package mc_arb_pkg;

  localparam logic REQ_WRITE = 1'b1;
  localparam logic REQ_READ  = 1'b0;

  // Requester id width. A single-bit id is kept even for NUM_REQ <= 2, so
  // that every id vector has a legal non-zero width.
  function automatic int id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  localparam int MC_NUM_REQ = 4;
  localparam int MC_ADDR_W  = 30;
  localparam int MC_DATA_W  = 16;
  localparam int MC_ID_W    = id_w(MC_NUM_REQ);

  typedef struct packed {
    logic                 req_type;
    logic [MC_ADDR_W-1:0] addr;
    logic [MC_DATA_W-1:0] data;
    logic [MC_ID_W-1:0]   id;
  } mc_req_t;

endpackage

// File: rtl/mc_tag_fifo.sv
// rtl/mc_tag_fifo.sv - ownership tag FIFO recording which requester owns each outstanding access
//
// Purpose: synchronous FIFO of requester ids, read in order as completions return.
// Ports:   clk, rst_n           clock / async active-low reset
//          push, push_data      enqueue an id (ignored when full)
//          pop                  dequeue the head (ignored when empty)
//          head                 current head id
//          full, empty, count   occupancy status
module mc_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mc_request_arbiter.sv
// rtl/mc_request_arbiter.sv - round-robin front end sharing one memory_controller request port
//
// Purpose: grants one requester per cycle into a one-entry output slot that
//          honours out_busy, and routes read/write completions back to their
//          owners in order via two ownership FIFOs.
// Ports:   clk, rst_n                           clock / async active-low reset
//          req_valid, req_type, req_addr,
//          req_data, req_ready                  per-requester request handshake
//          in_valid, in_request_*, out_busy     controller request port
//          read_done, write_done, data_out      controller completions
//          rsp_rd_valid, rsp_wr_valid, rsp_data per-requester completions
//          err_orphan                           completion with no owner
module mc_request_arbiter
  import mc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_type,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          in_valid,
  output logic                          in_request_type,
  output logic [ADDR_WIDTH-1:0]         in_request_address,
  output logic [DATA_WIDTH-1:0]         in_request_data,
  input  logic                          out_busy,
  input  logic                          read_done,
  input  logic                          write_done,
  input  logic [DATA_WIDTH-1:0]         data_out,
  output logic [NUM_REQ-1:0]            rsp_rd_valid,
  output logic [NUM_REQ-1:0]            rsp_wr_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          err_orphan
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam int CW   = $clog2(TAG_DEPTH) + 1;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;
  logic               slot_free;
  logic [NUM_REQ-1:0] elig;

  logic               rd_full, rd_empty, wr_full, wr_empty;
  logic [ID_W-1:0]    rd_head, wr_head;
  logic [CW-1:0]      rd_count, wr_count;
  logic               rd_push, wr_push, rd_pop, wr_pop;

  // The slot can take a new request when empty or when being drained now.
  assign slot_free = !in_valid || !out_busy;

  // Full flags ignore a same-cycle pop, so a full FIFO is never pushed.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (req_type[i] == REQ_WRITE ? !wr_full : !rd_full);
    end
  end

  // Search from rr_ptr upward with wrap; first eligible index wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_vld && slot_free && elig[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
  assign rd_push   = grant_vld && (req_type[grant_id] == REQ_READ);
  assign wr_push   = grant_vld && (req_type[grant_id] == REQ_WRITE);
  assign rd_pop    = read_done && !rd_empty;
  assign wr_pop    = write_done && !wr_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr             <= '0;
      in_valid           <= 1'b0;
      in_request_type    <= 1'b0;
      in_request_address <= '0;
      in_request_data    <= '0;
    end else if (grant_vld) begin
      rr_ptr             <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      in_valid           <= 1'b1;
      in_request_type    <= req_type[grant_id];
      in_request_address <= req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
      in_request_data    <= req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end else if (in_valid && !out_busy) begin
      in_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rd_valid <= '0;
      rsp_wr_valid <= '0;
      rsp_data     <= '0;
      err_orphan   <= 1'b0;
    end else begin
      rsp_rd_valid <= rd_pop ? (NUM_REQ'(1) << rd_head) : '0;
      rsp_wr_valid <= wr_pop ? (NUM_REQ'(1) << wr_head) : '0;
      if (rd_pop) rsp_data <= data_out;
      err_orphan   <= (read_done && rd_empty) || (write_done && wr_empty);
    end
  end

  mc_tag_fifo #(.WIDTH(ID_W), .DEPTH(TAG_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_push),
    .push_data (grant_id),
    .pop       (rd_pop),
    .head      (rd_head),
    .full      (rd_full),
    .empty     (rd_empty),
    .count     (rd_count)
  );

  mc_tag_fifo #(.WIDTH(ID_W), .DEPTH(TAG_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_push),
    .push_data (grant_id),
    .pop       (wr_pop),
    .head      (wr_head),
    .full      (wr_full),
    .empty     (wr_empty),
    .count     (wr_count)
  );

endmodule

// File: tb/tb_mc_request_arbiter.sv
// tb/tb_mc_request_arbiter.sv - directed table-driven bench for mc_request_arbiter
module tb_mc_request_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 30;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_type = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             in_valid;
  logic             in_request_type;
  logic [AW-1:0]    in_request_address;
  logic [DW-1:0]    in_request_data;
  logic             out_busy = 1'b0;
  logic             read_done = 1'b0;
  logic             write_done = 1'b0;
  logic [DW-1:0]    data_out = '0;
  logic [NR-1:0]    rsp_rd_valid;
  logic [NR-1:0]    rsp_wr_valid;
  logic [DW-1:0]    rsp_data;
  logic             err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mc_request_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data),
    .in_valid(in_valid), .in_request_type(in_request_type),
    .in_request_address(in_request_address), .in_request_data(in_request_data),
    .out_busy(out_busy), .read_done(read_done), .write_done(write_done),
    .data_out(data_out), .rsp_rd_valid(rsp_rd_valid), .rsp_wr_valid(rsp_wr_valid),
    .rsp_data(rsp_data), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [3:0]  rv, rt;
    logic        busy, rdd, wrd;
    logic [15:0] dout;
    logic [3:0]  e_rdy;
    logic        e_iv, e_type;
    logic [29:0] e_addr;
    logic [3:0]  e_rrd, e_rwr;
    logic [15:0] e_rdata;
    logic        e_orph;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [3:0] rv, rt, input logic busy, rdd, wrd,
                              input logic [15:0] dout, input logic [3:0] e_rdy,
                              input logic e_iv, e_type, input logic [29:0] e_addr,
                              input logic [3:0] e_rrd, e_rwr, input logic [15:0] e_rdata,
                              input logic e_orph);
    vec_t v;
    v.rv = rv; v.rt = rt; v.busy = busy; v.rdd = rdd; v.wrd = wrd; v.dout = dout;
    v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_type = e_type; v.e_addr = e_addr;
    v.e_rrd = e_rrd; v.e_rwr = e_rwr; v.e_rdata = e_rdata; v.e_orph = e_orph;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, settle, then let the caller check.
  task automatic drive(input logic [3:0] rv, rt, input logic busy, rdd, wrd,
                       input logic [15:0] dout);
    @(negedge clk);
    req_valid = rv; req_type = rt; out_busy = busy;
    read_done = rdd; write_done = wrd; data_out = dout;
    #1;
  endtask

  task automatic set_addr(input int i, input logic [29:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = AW'(32'h10 + i);
      req_data[i*DW +: DW] = DW'(32'hD0 + i);
    end

    tbl[0]  = mk(4'hF, 4'hF, 0, 0, 0, 16'h0, 4'h1, 0, 0, 30'h00, 4'h0, 4'h0, 16'h0, 0);
    tbl[1]  = mk(4'hF, 4'hF, 0, 0, 0, 16'h0, 4'h2, 1, 1, 30'h10, 4'h0, 4'h0, 16'h0, 0);
    tbl[2]  = mk(4'hF, 4'hF, 0, 0, 0, 16'h0, 4'h4, 1, 1, 30'h11, 4'h0, 4'h0, 16'h0, 0);
    tbl[3]  = mk(4'hF, 4'hF, 0, 0, 0, 16'h0, 4'h8, 1, 1, 30'h12, 4'h0, 4'h0, 16'h0, 0);
    tbl[4]  = mk(4'hF, 4'hF, 0, 0, 0, 16'h0, 4'h1, 1, 1, 30'h13, 4'h0, 4'h0, 16'h0, 0);
    tbl[5]  = mk(4'h0, 4'h0, 0, 0, 0, 16'h0, 4'h0, 1, 1, 30'h10, 4'h0, 4'h0, 16'h0, 0);
    tbl[6]  = mk(4'h0, 4'h0, 0, 0, 1, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h0, 16'h0, 0);
    tbl[7]  = mk(4'h0, 4'h0, 0, 0, 1, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h1, 16'h0, 0);
    tbl[8]  = mk(4'h0, 4'h0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h2, 16'h0, 0);
    tbl[9]  = mk(4'h0, 4'h0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h0, 16'h0, 0);
    tbl[10] = mk(4'h0, 4'h0, 0, 0, 1, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h0, 16'h0, 0);
    tbl[11] = mk(4'h0, 4'h0, 0, 0, 1, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h4, 16'h0, 0);
    tbl[12] = mk(4'h0, 4'h0, 0, 0, 1, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h8, 16'h0, 0);
    tbl[13] = mk(4'h0, 4'h0, 0, 0, 1, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h1, 16'h0, 0);
    tbl[14] = mk(4'h0, 4'h0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h0, 16'h0, 1);
    tbl[15] = mk(4'h0, 4'h0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h0, 16'h0, 0);
    tbl[16] = mk(4'h2, 4'h0, 0, 0, 0, 16'h0, 4'h2, 0, 0, 30'h00, 4'h0, 4'h0, 16'h0, 0);
    tbl[17] = mk(4'h8, 4'h0, 0, 0, 0, 16'h0, 4'h8, 1, 0, 30'h11, 4'h0, 4'h0, 16'h0, 0);
    tbl[18] = mk(4'h2, 4'h0, 0, 0, 0, 16'h0, 4'h2, 1, 0, 30'h13, 4'h0, 4'h0, 16'h0, 0);
    tbl[19] = mk(4'h0, 4'h0, 0, 1, 0, 16'hA, 4'h0, 1, 0, 30'h11, 4'h0, 4'h0, 16'h0, 0);
    tbl[20] = mk(4'h0, 4'h0, 0, 1, 0, 16'hB, 4'h0, 0, 0, 30'h00, 4'h2, 4'h0, 16'hA, 0);
    tbl[21] = mk(4'h0, 4'h0, 0, 1, 0, 16'hC, 4'h0, 0, 0, 30'h00, 4'h8, 4'h0, 16'hB, 0);
    tbl[22] = mk(4'h0, 4'h0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 30'h00, 4'h2, 4'h0, 16'hC, 0);
    tbl[23] = mk(4'h0, 4'h0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 30'h00, 4'h0, 4'h0, 16'hC, 0);

    // Reset state
    #2;
    chk("reset_in_valid", 64'(in_valid), 64'h0);
    chk("reset_rsp_rd", 64'(rsp_rd_valid), 64'h0);
    chk("reset_rsp_wr", 64'(rsp_wr_valid), 64'h0);
    chk("reset_orphan", 64'(err_orphan), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin, write routing, orphan, read routing
    for (int r = 0; r < 24; r++) begin
      drive(tbl[r].rv, tbl[r].rt, tbl[r].busy, tbl[r].rdd, tbl[r].wrd, tbl[r].dout);
      chk($sformatf("v%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].e_rdy));
      chk($sformatf("v%0d_in_valid", r), 64'(in_valid), 64'(tbl[r].e_iv));
      if (tbl[r].e_iv) begin
        chk($sformatf("v%0d_in_addr", r), 64'(in_request_address), 64'(tbl[r].e_addr));
        chk($sformatf("v%0d_in_type", r), 64'(in_request_type), 64'(tbl[r].e_type));
      end
      chk($sformatf("v%0d_rsp_rd", r), 64'(rsp_rd_valid), 64'(tbl[r].e_rrd));
      chk($sformatf("v%0d_rsp_wr", r), 64'(rsp_wr_valid), 64'(tbl[r].e_rwr));
      chk($sformatf("v%0d_rsp_data", r), 64'(rsp_data), 64'(tbl[r].e_rdata));
      chk($sformatf("v%0d_orphan", r), 64'(err_orphan), 64'(tbl[r].e_orph));
    end

    // Backpressure: requester 2 write at 0x15, busy for 5 cycles (rr_ptr = 2)
    set_addr(2, 30'h15);
    drive(4'h4, 4'h4, 1, 0, 0, 16'h0);
    chk("bp_grant2", 64'(req_ready), 64'h4);
    for (int c = 0; c < 5; c++) begin
      drive(4'h1, 4'h1, 1, 0, 0, 16'h0);
      chk($sformatf("bp%0d_no_grant", c), 64'(req_ready), 64'h0);
      chk($sformatf("bp%0d_in_valid", c), 64'(in_valid), 64'h1);
      chk($sformatf("bp%0d_in_addr", c), 64'(in_request_address), 64'h15);
      chk($sformatf("bp%0d_in_data", c), 64'(in_request_data), 64'hD2);
    end
    drive(4'h1, 4'h1, 0, 0, 0, 16'h0);
    chk("bp_accept_in_addr", 64'(in_request_address), 64'h15);
    chk("bp_accept_grant0", 64'(req_ready), 64'h1);
    drive(4'h0, 4'h0, 0, 0, 0, 16'h0);
    chk("bp_next_in_addr", 64'(in_request_address), 64'h10);
    chk("bp_next_in_valid", 64'(in_valid), 64'h1);
    drive(4'h0, 4'h0, 0, 0, 0, 16'h0);
    chk("bp_drained", 64'(in_valid), 64'h0);

    // Read FIFO full: 16 reads from requester 0 (rr_ptr = 1)
    for (int c = 0; c < 16; c++) begin
      drive(4'h1, 4'h0, 0, 0, 0, 16'h0);
      chk($sformatf("fill%0d_grant", c), 64'(req_ready), 64'h1);
    end
    drive(4'h3, 4'h2, 0, 0, 0, 16'h0);
    chk("full_write_granted", 64'(req_ready), 64'h2);
    drive(4'h1, 4'h0, 0, 1, 0, 16'h55);
    chk("full_pop_same_cycle", 64'(req_ready), 64'h0);
    drive(4'h1, 4'h0, 0, 0, 0, 16'h0);
    chk("full_after_pop_grant", 64'(req_ready), 64'h1);
    chk("full_pop_rsp_rd", 64'(rsp_rd_valid), 64'h1);
    chk("full_pop_rsp_data", 64'(rsp_data), 64'h55);

    // Drain to 3 outstanding reads, then reset mid-traffic
    for (int c = 0; c < 13; c++) drive(4'h0, 4'h0, 0, 1, 0, 16'h0);
    drive(4'h0, 4'h0, 0, 0, 0, 16'h0);
    chk("pre_reset_orphan", 64'(err_orphan), 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_in_valid", 64'(in_valid), 64'h0);
    chk("rst_in_type", 64'(in_request_type), 64'h0);
    chk("rst_in_addr", 64'(in_request_address), 64'h0);
    chk("rst_in_data", 64'(in_request_data), 64'h0);
    chk("rst_rsp_rd", 64'(rsp_rd_valid), 64'h0);
    chk("rst_rsp_wr", 64'(rsp_wr_valid), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);
    chk("rst_orphan", 64'(err_orphan), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'hF, 4'hF, 0, 0, 0, 16'h0);
    chk("post_rst_rr_ptr0", 64'(req_ready), 64'h1);
    drive(4'h0, 4'h0, 0, 1, 0, 16'h77);
    drive(4'h0, 4'h0, 0, 0, 0, 16'h0);
    chk("post_rst_orphan", 64'(err_orphan), 64'h1);
    chk("post_rst_no_rsp", 64'(rsp_rd_valid), 64'h0);
    drive(4'h0, 4'h0, 0, 0, 0, 16'h0);
    chk("post_rst_orphan_1cyc", 64'(err_orphan), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
